instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
Inverse of the core's immediate extender. It accepts decoded instruction fields (format, registers, functs, signed immediate) over a valid/ready handshake. It range- and alignment-checks the immediate, packs a 32-bit RV32I word, and writes it to consecutive instruction-memory addresses through a write handshake. It sits between the test/boot loader and the instruction memory and fills program memory before the core is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after reset or restart

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
restart  in  1  synchronous pulse: abort, clear flags, address := BASE_ADDR
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept bundle
in_fmt  in  3  0=R 1=I(OP-IMM) 2=LOAD 3=STORE 4=BRANCH 5=JAL 6=JALR 7=reserved
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field (R only)
in_imm  in  32  signed byte-offset immediate
in_last  in  1  final instruction of program
mem_we  out  1  write request
mem_ready  in  1  memory accepts write this cycle
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded instruction
busy  out  1  state != IDLE/DONE/ERROR
done  out  1  sticky, last word written
err  out  1  sticky error
err_code  out  3  0 none, 1 range, 2 align, 3 bad fmt, 4 addr overflow

Behaviour:
- Reset: state IDLE; in_ready=1; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; busy=0; done=0; err=0; err_code=0.
- FSM states: IDLE, ENCODE, WRITE, DONE, ERROR.
- IDLE: in_ready=1. When in_valid&in_ready, register all fields and go to ENCODE. in_ready=0 in all other states.
- ENCODE, one cycle: check the fields and build the word.
  - If an error is found: go to ERROR and set err/err_code.
  - Otherwise: load mem_wdata and go to WRITE.
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
- Bit packing must exactly invert the extender:
  - I/LOAD/JALR: imm[11:0] -> [31:20].
  - STORE: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - BRANCH: imm[12] -> [31], imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> [7].
  - JAL: imm[20] -> [31], imm[10:1] -> [30:21], imm[11] -> [20], imm[19:12] -> [19:12].
  - R uses funct7, rs2, rs1, funct3, rd; in_imm is ignored.
  - Fields unused by a format are zero: no rs2/funct7 for I-types; no rd for STORE/BRANCH; no rs1/funct3 for JAL.
- Range checks (code 1):
  - I/LOAD/JALR/STORE: in_imm[31:11] all equal.
  - BRANCH: in_imm[31:12] all equal.
  - JAL: in_imm[31:20] all equal.
- Align check (code 2): BRANCH/JAL with in_imm[0]=1.
- Format check (code 3): fmt 7.
- Error priority: 3 > 1 > 2.
- WRITE: mem_we=1 and mem_addr/mem_wdata held stable until mem_ready. On the handshake cycle:
  - If last: go to DONE.
  - Else if mem_addr is all ones: set code 4 and go to ERROR; no wrap.
  - Else: mem_addr+1 and go to IDLE.
  - mem_we drops the cycle after the handshake.
- Latency: accept at cycle t, mem_we asserted at t+2, earliest next accept at t+3 with mem_ready=1. Back-to-back throughput is one word per 3 cycles.
- DONE/ERROR: sticky and ignore in_valid; only restart or rst_n leaves them.
- restart: highest priority in any state, including mid-WRITE with mem_ready high (that write is not counted). Next cycle: IDLE, mem_we=0, done=err=0, err_code=0, mem_addr=BASE_ADDR.
- rst_n asserted mid-operation: immediate return to reset values, asynchronously.

Decomposition:
- Shared package (e.g. riscv_pkg): 7-bit opcode constants; in_fmt enum; err_code enum; FSM state typedef. The existing immediate extender should switch to the same opcode constants.
- One sub-module, imm_packer: combinational; in_fmt + in_imm + fields -> instruction word + range/align/format error flags. It is the exact inverse of the extender and is reusable in the bench.

Test Plan:
- I: fmt1, rd=1, rs1=0, f3=0, imm=5 -> mem_wdata 0x00500093 at addr 0, mem_we at t+2; in_ready back high at t+3.
- STORE/BRANCH/JAL with mem_ready stalled 3 cycles:
  - sw: rs1=1, rs2=2, f3=2, imm=12 -> 0x0020A623 at addr 0.
  - beq: x0, x0, imm=-4 -> 0xFE000EE3 at addr 1.
  - jal: rd=1, imm=8, last=1 -> 0x008000EF at addr 2.
  - Addresses and data are stable through the stall; done=1 after the final write.
- Errors:
  - I with imm=2048 -> err=1, code 1, no mem_we.
  - After restart, BRANCH imm=3 -> code 2.
  - After restart, fmt=7 with imm=4096 -> code 3 (priority).
- Overflow: ADDR_W=2, four non-last writes -> fourth writes addr 3, then err code 4; no wrap to 0.
- restart on the mem_ready cycle of word 1 -> next cycle mem_we=0, addr=0, flags clear; the next bundle is written at addr 0.
- Round trip: 1000 random legal bundles per format -> the extender applied to mem_wdata equals in_imm (bit 0 is zero for BRANCH/JAL).

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_pkg
// Shared RV32I definitions for the instruction encoder/loader and the core's
// immediate extender: 7-bit opcode constants, the loader's field-format and
// error-code enumerations, the loader FSM state type, and a helper that tests
// whether a 32-bit value is a proper sign extension above a given bit.
// -----------------------------------------------------------------------------
package instr_encoder_loader_pkg;

  // Major opcodes (instr[6:0]) shared with the immediate extender.
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Encoding of the loader's in_fmt field.
  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_LOAD   = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_BRANCH = 3'd4,
    FMT_JAL    = 3'd5,
    FMT_JALR   = 3'd6,
    FMT_RSVD   = 3'd7
  } fmt_e;

  // Sticky error codes reported on err_code.
  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_RANGE = 3'd1,
    ERR_ALIGN = 3'd2,
    ERR_FMT   = 3'd3,
    ERR_OVF   = 3'd4
  } err_e;

  // Loader FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ENCODE = 3'd1;
  localparam state_t ST_WRITE  = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_ERROR  = 3'd4;

  // True when v[31:msb] are all equal, i.e. v fits in a signed field whose
  // sign bit is at position msb.
  function automatic logic imm_fits(input logic [31:0] v, input int msb);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= msb) begin
        all_one  = all_one & v[i];
        all_zero = all_zero & ~v[i];
      end
    end
    return all_one | all_zero;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_imm_packer.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_imm_packer (the imm_packer sub-block)
// Purely combinational RV32I encoder: the exact inverse of the immediate
// extender. Packs decoded fields into a 32-bit instruction word and flags
// immediates that do not fit / are misaligned, and reserved formats.
// Ports:
//   i_fmt      format selector (fmt_e encoding)
//   i_rd/i_rs1/i_rs2, i_funct3, i_funct7   register and function fields
//   i_imm      signed byte-offset immediate
//   o_word     packed instruction (fields unused by the format are zero)
//   o_range_err, o_align_err, o_fmt_err    independent error flags
// -----------------------------------------------------------------------------
module instr_encoder_loader_imm_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_range_err,
  output logic        o_align_err,
  output logic        o_fmt_err
);

  // Per-format bit packing and legality checks.
  always_comb begin
    o_word      = 32'h0000_0000;
    o_range_err = 1'b0;
    o_align_err = 1'b0;
    o_fmt_err   = 1'b0;
    case (fmt_e'(i_fmt))
      FMT_R: begin
        o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPC_R};
      end
      FMT_I: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_OPIMM};
        o_range_err = ~imm_fits(i_imm, 11);
      end
      FMT_LOAD: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
        o_range_err = ~imm_fits(i_imm, 11);
      end
      FMT_JALR: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_JALR};
        o_range_err = ~imm_fits(i_imm, 11);
      end
      FMT_STORE: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
        o_range_err = ~imm_fits(i_imm, 11);
      end
      FMT_BRANCH: begin
        // B-type scatters the 13-bit offset; bit 0 is implied zero.
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], OPC_BRANCH};
        o_range_err = ~imm_fits(i_imm, 12);
        o_align_err = i_imm[0];
      end
      FMT_JAL: begin
        // J-type scatters the 21-bit offset; bit 0 is implied zero.
        o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
        o_range_err = ~imm_fits(i_imm, 20);
        o_align_err = i_imm[0];
      end
      default: begin
        o_fmt_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts decoded instruction bundles over a valid/ready handshake, encodes
// them into RV32I words and writes them to consecutive instruction-memory
// word addresses, starting at BASE_ADDR. Used to fill program memory before
// the core leaves reset.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   restart          synchronous abort: clear flags, address := BASE_ADDR
//   in_valid/in_ready  bundle handshake; in_fmt, in_rd, in_rs1, in_rs2,
//                    in_funct3, in_funct7, in_imm, in_last form the bundle
//   mem_we/mem_ready write handshake; mem_addr, mem_wdata held until accepted
//   busy             encoding or writing in progress
//   done, err        sticky completion / error flags; err_code gives cause
// -----------------------------------------------------------------------------
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [2:0]         r_fmt;
  logic [4:0]         r_rd;
  logic [4:0]         r_rs1;
  logic [4:0]         r_rs2;
  logic [2:0]         r_funct3;
  logic [6:0]         r_funct7;
  logic [31:0]        r_imm;
  logic               r_last;
  logic               r_in_ready;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [2:0]         r_err_code;

  logic [31:0]        w_word;
  logic               w_range_err;
  logic               w_align_err;
  logic               w_fmt_err;

  instr_encoder_loader_imm_packer u_imm_packer (
    .i_fmt       (r_fmt),
    .i_rd        (r_rd),
    .i_rs1       (r_rs1),
    .i_rs2       (r_rs2),
    .i_funct3    (r_funct3),
    .i_funct7    (r_funct7),
    .i_imm       (r_imm),
    .o_word      (w_word),
    .o_range_err (w_range_err),
    .o_align_err (w_align_err),
    .o_fmt_err   (w_fmt_err)
  );

  // Loader FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fmt       <= 3'd0;
      r_rd        <= 5'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_funct3    <= 3'd0;
      r_funct7    <= 7'd0;
      r_imm       <= 32'h0000_0000;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE;
      r_mem_wdata <= 32'h0000_0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else if (restart) begin
      // Overrides everything, including a write being accepted this cycle.
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= BASE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_fmt      <= in_fmt;
            r_rd       <= in_rd;
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_funct3   <= in_funct3;
            r_funct7   <= in_funct7;
            r_imm      <= in_imm;
            r_last     <= in_last;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          if (w_fmt_err || w_range_err || w_align_err) begin
            // Reserved format outranks range, range outranks alignment.
            r_state <= ST_ERROR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            if (w_fmt_err) begin
              r_err_code <= ERR_FMT;
            end else if (w_range_err) begin
              r_err_code <= ERR_RANGE;
            end else begin
              r_err_code <= ERR_ALIGN;
            end
          end else begin
            r_mem_wdata <= w_word;
            r_mem_we    <= 1'b1;
            r_state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
            if (r_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (&r_mem_addr) begin
              // Top of memory reached with more words to come: stop, no wrap.
              r_state    <= ST_ERROR;
              r_err      <= 1'b1;
              r_err_code <= ERR_OVF;
            end else begin
              r_mem_addr <= r_mem_addr + ADDR_ONE;
              r_in_ready <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          // Sticky until restart or reset.
          r_state <= r_state;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
          r_mem_we   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
